mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- LC-3 memory access unit holding MAR and MDR.
- Loads MAR/MDR from the processor BUS and runs variable-latency read/write transactions on an external memory port.
- Returns the LC-3 ready signal R to the control FSM, and drives MDR back toward the BUS gate.
- Sits between the datapath (PC/MARMUX results arrive via BUS) and the memory/device array.

Parameters:
- ADDR_W, 16, memory address width (MAR width).
- DATA_W, 16, data width (MDR and BUS width).
- TIMEOUT, 255, cycles to wait for mem_ack before aborting; 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- BUS  input  DATA_W  processor bus; source for MAR and for MDR when MIO_EN=0.
- ldMAR  input  1  load MAR from BUS.
- ldMDR  input  1  load MDR (from BUS when MIO_EN=0).
- MIO_EN  input  1  request a memory transaction.
- R_W  input  1  transaction direction: 0=read, 1=write; sampled at transaction start.
- MAROut  output  ADDR_W  current MAR.
- MDROut  output  DATA_W  current MDR, for gateMDR.
- R  output  1  ready; one-cycle pulse when a transaction completes.
- err  output  1  last transaction timed out.
- mem_addr  output  ADDR_W  transaction address.
- mem_wdata  output  DATA_W  write data.
- mem_req  output  1  transaction request.
- mem_we  output  1  1=write, 0=read.
- mem_rdata  input  DATA_W  read data, valid with mem_ack.
- mem_ack  input  1  memory completion strobe.

Behaviour:
- Reset (rst=0, async): MAR=0, MDR=0, state=IDLE, R=0, err=0, mem_req=0, mem_we=0.
  - Outputs remain at reset values until the first clk edge after rst deasserts.
  - Reset during BUSY aborts the transaction immediately; no R pulse.
- States: IDLE, BUSY, DONE.
- IDLE:
  - ldMAR=1 -> MAR<=BUS.
  - ldMDR=1 and MIO_EN=0 -> MDR<=BUS.
  - MIO_EN=1 -> latch dir<=R_W, clear err, counter<=0, go BUSY.
  - If ldMAR and MIO_EN are both asserted in the same cycle, the transaction uses the OLD MAR. The control FSM sequences ldMAR before MIO_EN.
- BUSY:
  - mem_req=1 and mem_we=dir, both registered and stable for the whole of BUSY.
  - mem_addr=MAR; mem_wdata=MDR.
  - ldMAR and BUS-sourced ldMDR are ignored (MAR/MDR frozen).
  - mem_ack=1 -> read: MDR<=mem_rdata on that edge; write: MDR unchanged. Then go DONE and drop mem_req.
  - counter increments each BUSY cycle without ack. If TIMEOUT!=0 and counter reaches TIMEOUT-1 without ack: err<=1, MDR<=all-ones (reads only), go DONE.
  - Ack and timeout on the same cycle: ack wins, err stays 0.
- DONE:
  - R=1 for exactly this cycle; go IDLE.
  - mem_req=0.
  - ldMAR and ldMDR are honoured as in IDLE.
- Latency:
  - Minimum MIO_EN-to-R latency is 3 cycles (IDLE->BUSY edge, ack in the first BUSY cycle, R in DONE).
  - Back-to-back transactions have a one-cycle IDLE bubble. MIO_EN held high through DONE starts the next transaction from IDLE.
- mem_ack outside BUSY is ignored.
- err is sticky until the next transaction starts.
- R is never asserted outside DONE.
- MAROut and MDROut always reflect the registers, no bypass.

Test Plan:
- Reset mid-BUSY:
  - Stimulus: start a read, assert rst=0 asynchronously in the 2nd BUSY cycle.
  - Required: mem_req falls without waiting for clk; MAR=0, MDR=0, no R pulse.
- Read:
  - Stimulus: BUS=16'h3000 with ldMAR; next cycle MIO_EN=1, R_W=0; memory acks 2 cycles after req with rdata=16'hABCD.
  - Required: mem_addr=16'h3000, mem_we=0; MDROut=16'hABCD; R pulses once, 4 cycles after MIO_EN.
- Write:
  - Stimulus: MAR=16'hFE06, BUS=16'h0041 with ldMDR, then MIO_EN=1, R_W=1; immediate ack.
  - Required: mem_we=1, mem_wdata=16'h0041; MDR unchanged; R after 3 cycles.
- Freeze in BUSY:
  - Stimulus: ldMAR with BUS=16'h1234 and ldMDR while BUSY.
  - Required: mem_addr and MDR unchanged until DONE.
- Timeout:
  - Stimulus: TIMEOUT=4, read with no ack.
  - Required: R after 4 BUSY cycles, err=1, MDR=16'hFFFF; err clears on the next MIO_EN start.
- Back-to-back:
  - Stimulus: MIO_EN held high across two reads (addresses 16'h0000, then 16'h0001 loaded during DONE).
  - Required: two R pulses separated by the IDLE bubble; second read addresses 16'h0001.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: LC-3 MAR/MDR holder running variable-latency transactions on an external memory port.
module mem_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] BUS,
    input  logic              ldMAR,
    input  logic              ldMDR,
    input  logic              MIO_EN,
    input  logic              R_W,
    output logic [ADDR_W-1:0] MAROut,
    output logic [DATA_W-1:0] MDROut,
    output logic              R,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic [CW-1:0] cnt;
    logic start, to_hit;
    assign start = (state == IDLE) && MIO_EN;
    assign to_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
    assign MAROut = mar;
    assign MDROut = mdr;
    assign mem_addr = mar;
    assign mem_wdata = mdr;
    // A starting transaction uses the MAR it sees, so a simultaneous ldMAR is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            mar     <= '0;
            mdr     <= '0;
            cnt     <= '0;
            R       <= 1'b0;
            err     <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
        end else begin
            R <= 1'b0;
            if (state == BUSY) begin
                if (mem_ack || to_hit) begin
                    state   <= DONE;
                    R       <= 1'b1;
                    err     <= !mem_ack;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    if (!mem_we) mdr <= mem_ack ? mem_rdata : '1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                state <= start ? BUSY : IDLE;
                if (ldMAR && !start) mar <= BUS[ADDR_W-1:0];
                if (ldMDR && !MIO_EN) mdr <= BUS;
                if (start) begin
                    mem_req <= 1'b1;
                    mem_we  <= R_W;
                    err     <= 1'b0;
                    cnt     <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: table-driven, hand-written and randomized checks of mem_ctrl against a transaction-level model.
module tb_mem_ctrl;
    localparam int TO = 4;
    logic clk = 0, rst = 0;
    logic [15:0] BUS = 0, mem_rdata = 0;
    logic ldMAR = 0, ldMDR = 0, MIO_EN = 0, R_W = 0, mem_ack = 0;
    logic [15:0] MAROut, MDROut, mem_addr, mem_wdata;
    logic R, err, mem_req, mem_we;
    int passed = 0, total = 0;

    mem_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .BUS(BUS), .ldMAR(ldMAR), .ldMDR(ldMDR), .MIO_EN(MIO_EN), .R_W(R_W),
        .MAROut(MAROut), .MDROut(MDROut), .R(R), .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [15:0] addr, data;
        logic we;
        int ack_k;
        logic [15:0] rdata;
        int exp_busy;
        logic exp_err;
        logic [15:0] exp_mdr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Transaction-level model: busy length, error flag and final MDR from the ack position.
    task automatic model(input logic we, input int ack_k, input logic [15:0] data, input logic [15:0] rdata,
                         output int busy, output logic e, output logic [15:0] mdr);
        bit acked;
        acked = (ack_k >= 0) && (ack_k < TO);
        busy = acked ? ack_k + 1 : TO;
        e = !acked;
        mdr = we ? data : (acked ? rdata : 16'hFFFF);
    endtask

    task automatic run_txn(input vec_t v);
        int i;
        bit seen;
        @(negedge clk); ldMAR = 1; BUS = v.addr;
        @(negedge clk); ldMAR = 0; ldMDR = 1; BUS = v.data;
        @(negedge clk); ldMDR = 0; MIO_EN = 1; R_W = v.we;
        @(negedge clk); MIO_EN = 0;
        seen = 0;
        for (i = 0; i < 20; i++) begin
            if (R) begin seen = 1; break; end
            chk("busy_req", {31'd0, mem_req}, 1);
            chk("busy_addr", {16'd0, mem_addr}, {16'd0, v.addr});
            chk("busy_we", {31'd0, mem_we}, {31'd0, v.we});
            chk("busy_wdata", {16'd0, mem_wdata}, {16'd0, v.data});
            if (i == 0) chk("err_clear", {31'd0, err}, 0);
            mem_ack = (i == v.ack_k);
            mem_rdata = v.rdata;
            ldMAR = 1'($urandom); ldMDR = 1'($urandom); BUS = 16'($urandom);
            @(negedge clk);
        end
        mem_ack = 0; ldMAR = 0; ldMDR = 0;
        chk("R_seen", {31'd0, seen}, 1);
        chk("busy_len", i, v.exp_busy);
        chk("err", {31'd0, err}, {31'd0, v.exp_err});
        chk("mdr", {16'd0, MDROut}, {16'd0, v.exp_mdr});
        chk("done_req", {31'd0, mem_req}, 0);
        chk("mar", {16'd0, MAROut}, {16'd0, v.addr});
        @(negedge clk);
        chk("R_pulse", {31'd0, R}, 0);
        chk("err_sticky", {31'd0, err}, {31'd0, v.exp_err});
    endtask

    vec_t tbl[6];

    initial begin
        vec_t v;
        logic [15:0] keep;
        tbl[0] = '{16'h3000, 16'h1111, 1'b0, 1, 16'hABCD, 2, 1'b0, 16'hABCD};
        tbl[1] = '{16'hFE06, 16'h0041, 1'b1, 0, 16'h0000, 1, 1'b0, 16'h0041};
        tbl[2] = '{16'h4000, 16'h2222, 1'b0, -1, 16'h5555, 4, 1'b1, 16'hFFFF};
        tbl[3] = '{16'h4001, 16'h3333, 1'b1, -1, 16'h0000, 4, 1'b1, 16'h3333};
        tbl[4] = '{16'h5000, 16'h4444, 1'b0, 3, 16'h7777, 4, 1'b0, 16'h7777};
        tbl[5] = '{16'h5001, 16'h5555, 1'b0, 0, 16'h0000, 1, 1'b0, 16'h0000};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, mem_req}, 0);
        chk("rst_mar", {16'd0, MAROut}, 0);
        rst = 1;
        @(negedge clk);
        chk("rst_mdr", {16'd0, MDROut}, 0);
        chk("rst_R", {31'd0, R}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_we", {31'd0, mem_we}, 0);

        foreach (tbl[k]) run_txn(tbl[k]);

        // Reset in the 2nd BUSY cycle aborts at once
        @(negedge clk); ldMAR = 1; BUS = 16'h6000;
        @(negedge clk); ldMAR = 0; ldMDR = 1; BUS = 16'h6666;
        @(negedge clk); ldMDR = 0; MIO_EN = 1; R_W = 0;
        @(negedge clk); MIO_EN = 0;
        chk("pre_rst_req", {31'd0, mem_req}, 1);
        @(posedge clk); #2 rst = 0;
        #1;
        chk("async_req", {31'd0, mem_req}, 0);
        chk("async_mar", {16'd0, MAROut}, 0);
        chk("async_mdr", {16'd0, MDROut}, 0);
        @(negedge clk); rst = 1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("post_rst_R", {31'd0, R}, 0);
            chk("post_rst_req", {31'd0, mem_req}, 0);
        end

        // Ack outside BUSY is ignored
        keep = MDROut;
        mem_ack = 1; mem_rdata = 16'hBEEF;
        repeat (2) @(negedge clk);
        mem_ack = 0;
        chk("idle_ack_mdr", {16'd0, MDROut}, {16'd0, keep});
        chk("idle_ack_R", {31'd0, R}, 0);

        // ldMAR together with MIO_EN: the old MAR is used
        ldMAR = 1; BUS = 16'h0010;
        @(negedge clk); BUS = 16'h0020; MIO_EN = 1; R_W = 0;
        @(negedge clk); ldMAR = 0; MIO_EN = 0;
        chk("old_mar", {16'd0, mem_addr}, 16'h0010);
        mem_ack = 1; mem_rdata = 16'h1357;
        @(negedge clk); mem_ack = 0;
        chk("old_mar_R", {31'd0, R}, 1);
        chk("old_mar_mdr", {16'd0, MDROut}, 16'h1357);

        // Back-to-back reads with MIO_EN held high
        @(negedge clk); ldMAR = 1; BUS = 16'h0000;
        @(negedge clk); ldMAR = 0; MIO_EN = 1; R_W = 0;
        @(negedge clk);
        chk("b2b_addr0", {16'd0, mem_addr}, 16'h0000);
        mem_ack = 1; mem_rdata = 16'h0A0A;
        @(negedge clk); mem_ack = 0;
        chk("b2b_R0", {31'd0, R}, 1);
        chk("b2b_mdr0", {16'd0, MDROut}, 16'h0A0A);
        ldMAR = 1; BUS = 16'h0001;
        @(negedge clk); ldMAR = 0;
        chk("b2b_bubble_R", {31'd0, R}, 0);
        chk("b2b_bubble_req", {31'd0, mem_req}, 0);
        chk("b2b_mar1", {16'd0, MAROut}, 16'h0001);
        @(negedge clk);
        chk("b2b_req1", {31'd0, mem_req}, 1);
        chk("b2b_addr1", {16'd0, mem_addr}, 16'h0001);
        mem_ack = 1; mem_rdata = 16'h0B0B;
        @(negedge clk); mem_ack = 0; MIO_EN = 0;
        chk("b2b_R1", {31'd0, R}, 1);
        chk("b2b_mdr1", {16'd0, MDROut}, 16'h0B0B);
        @(negedge clk);
        chk("b2b_end_R", {31'd0, R}, 0);

        // Randomized transactions against the model
        for (int n = 0; n < 40; n++) begin
            v.addr = 16'($urandom);
            v.data = 16'($urandom);
            v.we = 1'($urandom);
            v.ack_k = int'($urandom_range(0, 6)) - 1;
            v.rdata = 16'($urandom);
            model(v.we, v.ack_k, v.data, v.rdata, v.exp_busy, v.exp_err, v.exp_mdr);
            run_txn(v);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
